// File: rtl/key_debounce_pkg.sv
// Shared constants for the key debouncer: lane count, console key bit order
// and per-lane debounce counter width.
package key_debounce_pkg;

   localparam int KD_NUM_KEYS = 8;
   localparam int KD_CNT_W    = 8;

   // Bit positions match the console key_input register layout
   localparam int KEY_A     = 0;
   localparam int KEY_B     = 1;
   localparam int KEY_C     = 2;
   localparam int KEY_UP    = 3;
   localparam int KEY_DOWN  = 4;
   localparam int KEY_LEFT  = 5;
   localparam int KEY_RIGHT = 6;
   localparam int KEY_POWER = 7;

   typedef logic [KD_CNT_W-1:0] kd_cnt_t;

   function automatic kd_cnt_t kd_last_cnt(input int ticks);
      return kd_cnt_t'(ticks - 1);
   endfunction

endpackage

// File: rtl/key_debounce_lane.sv
// One key lane: two-flop synchroniser, tick-driven agreement counter,
// accepted level and single-cycle press/release pulses.
module key_debounce_lane
   import key_debounce_pkg::*;
#(
   parameter int DEBOUNCE_TICKS = 8
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_eval,
   input  logic i_raw,
   output logic o_active,
   output logic o_press,
   output logic o_rel
);

   localparam kd_cnt_t CNT_LAST = kd_last_cnt(DEBOUNCE_TICKS);

   logic    r_s1;
   logic    r_s2;
   logic    r_st;
   logic    r_press;
   logic    r_rel;
   kd_cnt_t r_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
      end else begin
         r_s1 <= i_raw;
         r_s2 <= r_s1;
      end
   end

   // Any agreeing tick restarts the count, so only an unbroken run of
   // DEBOUNCE_TICKS disagreeing samples flips the accepted level.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_st    <= 1'b0;
         r_cnt   <= '0;
         r_press <= 1'b0;
         r_rel   <= 1'b0;
      end else begin
         r_press <= 1'b0;
         r_rel   <= 1'b0;
         if (i_eval) begin
            if (r_s2 == r_st) begin
               r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
               r_st    <= r_s2;
               r_cnt   <= '0;
               r_press <= r_s2;
               r_rel   <= ~r_s2;
            end else begin
               r_cnt <= r_cnt + kd_cnt_t'(1);
            end
         end
      end
   end

   assign o_active = r_st;
   assign o_press  = r_press;
   assign o_rel    = r_rel;

endmodule

// File: rtl/key_debounce.sv
// Raw button vector conditioner: shared sample-tick prescaler feeding one
// debounce lane per key.
module key_debounce
   import key_debounce_pkg::*;
#(
   parameter int PRESCALE       = 256,
   parameter int DEBOUNCE_TICKS = 8,
   parameter int NUM_KEYS       = KD_NUM_KEYS
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                ce,
   input  logic [NUM_KEYS-1:0] keys_raw,
   output logic [NUM_KEYS-1:0] keys_active,
   output logic [NUM_KEYS-1:0] key_press,
   output logic [NUM_KEYS-1:0] key_release,
   output logic                sample_tick
);

   localparam logic [15:0] PCNT_LAST = 16'(PRESCALE - 1);

   logic [15:0] r_pcnt;
   logic        r_tick;
   logic        w_eval;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pcnt <= '0;
         r_tick <= 1'b0;
      end else begin
         r_tick <= 1'b0;
         if (ce) begin
            if (r_pcnt == PCNT_LAST) begin
               r_pcnt <= '0;
               r_tick <= 1'b1;
            end else begin
               r_pcnt <= r_pcnt + 16'd1;
            end
         end
      end
   end

   // A tick that lands while ce is low must not advance the lane counters
   assign w_eval      = r_tick & ce;
   assign sample_tick = r_tick;

   for (genvar g = 0; g < NUM_KEYS; g++) begin : g_lane
      key_debounce_lane #(
         .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
      ) u_lane (
         .i_clk   (clk),
         .i_rst_n (reset),
         .i_eval  (w_eval),
         .i_raw   (keys_raw[g]),
         .o_active(keys_active[g]),
         .o_press (key_press[g]),
         .o_rel   (key_release[g])
      );
   end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce (PRESCALE=4, DEBOUNCE_TICKS=3) with an
// event scoreboard checking every press/release pulse.
module tb_key_debounce;

   logic       clk;
   logic       reset;
   logic       ce;
   logic [7:0] keys_raw;
   logic [7:0] keys_active;
   logic [7:0] key_press;
   logic [7:0] key_release;
   logic       sample_tick;

   typedef struct {
      logic [7:0] press;
      logic [7:0] rel;
      logic [7:0] active;
   } ev_t;

   ev_t exp_q[$];
   ev_t mon_e;
   int  checks = 0;
   int  errors = 0;

   key_debounce #(
      .PRESCALE      (4),
      .DEBOUNCE_TICKS(3),
      .NUM_KEYS      (8)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .ce         (ce),
      .keys_raw   (keys_raw),
      .keys_active(keys_active),
      .key_press  (key_press),
      .key_release(key_release),
      .sample_tick(sample_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_ev(input logic [7:0] p, input logic [7:0] r, input logic [7:0] a);
      ev_t e;
      e.press  = p;
      e.rel    = r;
      e.active = a;
      exp_q.push_back(e);
   endtask

   // Waits for the next negedge at which sample_tick is visible
   task automatic wait_tick(input int limit);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!sample_tick && n < limit);
      check("tick_seen", 32'(sample_tick), 32'd1);
   endtask

   task automatic wait_active(input logic [7:0] target, input int limit,
                              output int n, output int t);
      n = 0;
      t = 0;
      while (n < limit) begin
         @(negedge clk);
         n++;
         if (sample_tick) t++;
         if (keys_active === target) break;
      end
   endtask

   // Scoreboard: every pulse cycle consumes exactly one expected event
   always @(negedge clk) begin
      if ((key_press | key_release) != 8'h00) begin
         if (exp_q.size() == 0) begin
            check("unexpected_event", {16'h0, key_press, key_release}, 32'h0);
         end else begin
            mon_e = exp_q.pop_front();
            check("ev_press", 32'(key_press), 32'(mon_e.press));
            check("ev_release", 32'(key_release), 32'(mon_e.rel));
            check("ev_active", 32'(keys_active), 32'(mon_e.active));
            check("ev_overlap", 32'(key_press & key_release), 32'h0);
         end
      end
   end

   initial begin
      int  n;
      int  t;
      bit  seen;
      bit  seen2;

      // Reset held with all keys pressed
      reset    = 1'b0;
      ce       = 1'b1;
      keys_raw = 8'hFF;
      push_ev(8'hFF, 8'h00, 8'hFF);
      repeat (3) @(negedge clk);
      check("rst_active", 32'(keys_active), 32'h0);
      check("rst_press", 32'(key_press), 32'h0);
      check("rst_release", 32'(key_release), 32'h0);
      check("rst_tick", 32'(sample_tick), 32'h0);
      reset = 1'b1;
      #1;
      check("rel_active", 32'(keys_active), 32'h0);
      wait_active(8'hFF, 20, n, t);
      check("held_active", 32'(keys_active), 32'hFF);
      check("held_latency_le15", 32'(n <= 15), 32'd1);
      check("held_ticks", 32'(t), 32'd3);
      @(negedge clk);
      check("held_press_1clk", 32'(key_press), 32'h0);

      push_ev(8'h00, 8'hFF, 8'h00);
      keys_raw = 8'h00;
      wait_active(8'h00, 30, n, t);
      check("all_release", 32'(keys_active), 32'h0);

      // Clean press / release on bit 2
      push_ev(8'h04, 8'h00, 8'h04);
      keys_raw = 8'h04;
      wait_active(8'h04, 30, n, t);
      check("b2_active", 32'(keys_active), 32'h04);
      @(negedge clk);
      check("b2_press_1clk", 32'(key_press), 32'h0);
      push_ev(8'h00, 8'h04, 8'h00);
      keys_raw = 8'h00;
      wait_active(8'h00, 30, n, t);
      check("b2_release", 32'(keys_active), 32'h0);

      // Bounce on bit 0: toggling every 3 clk never yields 3 agreeing ticks
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (i % 3 == 0) keys_raw[0] = ~keys_raw[0];
         @(negedge clk);
         if (keys_active[0]) seen = 1'b1;
      end
      keys_raw[0] = 1'b0;
      check("bounce_stable", 32'(seen), 32'h0);
      wait_tick(10);
      push_ev(8'h01, 8'h00, 8'h01);
      keys_raw[0] = 1'b1;
      wait_active(8'h01, 30, n, t);
      check("bounce_active", 32'(keys_active), 32'h01);
      check("bounce_ticks", 32'(t), 32'd3);
      check("bounce_latency", 32'(n), 32'd13);
      push_ev(8'h00, 8'h01, 8'h00);
      keys_raw[0] = 1'b0;
      wait_active(8'h00, 30, n, t);
      check("bounce_release", 32'(keys_active), 32'h0);

      // Short pulse on bit 5: only two disagreeing ticks
      wait_tick(10);
      keys_raw[5] = 1'b1;
      wait_tick(10);
      wait_tick(10);
      keys_raw[5] = 1'b0;
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (keys_active != 8'h00) seen = 1'b1;
      end
      check("short_pulse_ignored", 32'(seen), 32'h0);

      // ce gating on bit 3 after two disagreeing ticks
      wait_tick(10);
      keys_raw[3] = 1'b1;
      wait_tick(10);
      wait_tick(10);
      @(negedge clk);
      ce    = 1'b0;
      seen  = 1'b0;
      seen2 = 1'b0;
      repeat (50) begin
         @(negedge clk);
         if (sample_tick) seen = 1'b1;
         if (keys_active[3]) seen2 = 1'b1;
      end
      check("ce_no_tick", 32'(seen), 32'h0);
      check("ce_frozen", 32'(seen2), 32'h0);
      push_ev(8'h08, 8'h00, 8'h08);
      ce = 1'b1;
      wait_active(8'h08, 20, n, t);
      check("ce_resume_active", 32'(keys_active), 32'h08);
      check("ce_resume_ticks", 32'(t), 32'd1);
      push_ev(8'h00, 8'h08, 8'h00);
      keys_raw = 8'h00;
      wait_active(8'h00, 30, n, t);
      check("ce_release", 32'(keys_active), 32'h0);

      // Two lanes together, then reset during a pending release
      push_ev(8'h42, 8'h00, 8'h42);
      keys_raw = 8'h42;
      wait_active(8'h42, 30, n, t);
      check("multi_active", 32'(keys_active), 32'h42);
      keys_raw = 8'h00;
      wait_tick(10);
      wait_tick(10);
      reset = 1'b0;
      #1;
      check("midrst_active", 32'(keys_active), 32'h0);
      check("midrst_release", 32'(key_release), 32'h0);
      check("midrst_tick", 32'(sample_tick), 32'h0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      seen  = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (keys_active != 8'h00) seen = 1'b1;
      end
      check("post_rst_idle", 32'(seen), 32'h0);
      check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Conditions the raw, asynchronous 8-bit button vector from the host/HPS before it reaches the console top's `keys_active` input.
- Feeds the key_input register block and, through it, the key interrupt sources.
- Per key it does synchronisation, tick-based debouncing and single-cycle press/release event generation.
- Sits directly upstream of the console top, in the same clk domain.

Parameters:
- PRESCALE, 256, clk cycles per debounce sample tick; legal 1..65535.
- DEBOUNCE_TICKS, 8, consecutive disagreeing ticks required to accept a new level; legal 1..255.
- NUM_KEYS, 8, number of key lanes; the console uses 8.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- ce  input  1  clock enable; low freezes prescaler and all debounce counters.
- keys_raw  input  NUM_KEYS  asynchronous raw key levels, 1 = pressed.
- keys_active  output  NUM_KEYS  debounced key levels, 1 = pressed; drives the console top's keys_active.
- key_press  output  NUM_KEYS  one-clk pulse per key on accepted 0->1.
- key_release  output  NUM_KEYS  one-clk pulse per key on accepted 1->0.
- sample_tick  output  1  one-clk pulse marking a sample tick, for debug and bench alignment.

Behaviour:
- Reset is asserted while reset = 0, asynchronously. On assertion, all of the following clear to 0:
  - sync stages, prescaler, per-key counters;
  - keys_active, key_press, key_release, sample_tick.
- Synchroniser: two flops per lane, keys_raw -> s1 -> s2. s2 is the only value used downstream. s1/s2 update every clk regardless of ce.
- Prescaler:
  - Counter pcnt runs 0..PRESCALE-1 when ce = 1.
  - When pcnt == PRESCALE-1 and ce = 1: sample_tick = 1 (registered, asserted in the following cycle) and pcnt wraps to 0.
  - PRESCALE = 1 gives sample_tick on every ce cycle.
  - ce = 0 holds pcnt and suppresses ticks.
- Per-key debounce, evaluated only in the cycle a tick is registered. Let st = keys_active[i], cnt = counter[i] (8 bits).
  - If s2[i] == st: cnt <= 0.
  - Else if cnt == DEBOUNCE_TICKS-1: st <= s2[i], cnt <= 0, and pulse key_press[i] (if new st = 1) or key_release[i] (if new st = 0).
  - Else: cnt <= cnt+1.
  - Consequences:
    - A disagreement interrupted by even one agreeing tick restarts the count.
    - Glitches between ticks are invisible.
    - DEBOUNCE_TICKS = 1 accepts on the first disagreeing tick.
- Events:
  - key_press/key_release are registered and high for exactly one clk, in the same cycle keys_active changes.
  - Press and release on the same lane never coincide.
  - Multiple lanes may pulse in the same cycle.
- Latency: a clean raw edge is reflected on keys_active 2 clk (sync) + DEBOUNCE_TICKS ticks later, plus 1 clk register, plus up to PRESCALE clk of tick alignment.
- Counter saturation cannot occur: cnt never exceeds DEBOUNCE_TICKS-1.
- ce low mid-count: cnt is retained; counting resumes at the next tick after ce returns high.
- Reset mid-debounce: all state is lost and keys_active returns to 0; no release pulse is generated.
- Keys held through reset release: after release, a 0->1 press is detected normally once DEBOUNCE_TICKS ticks elapse.

Decomposition:
- Package key_debounce_pkg holds:
  - NUM_KEYS default;
  - key index constants (A, B, C, UP, DOWN, LEFT, RIGHT, POWER = bits 0..7), matching the console's key_input register bit order;
  - counter width constant (8).
- One sub-module, key_debounce_lane: synchroniser, counter, stable bit and event generation for a single key; instantiated NUM_KEYS times via generate.
- The prescaler is shared and lives in the top module.

Test Plan:
- Run all scenarios with PRESCALE = 4 and DEBOUNCE_TICKS = 3.
- Reset/idle: hold reset = 0 with keys_raw = 8'hFF, then release -> all outputs 0 at release; keys_active = 8'hFF after 2 clk + 3 ticks (≤ 15 clk); exactly one key_press pulse of 8'hFF.
- Clean press/release on bit 2: raise keys_raw[2] -> keys_active = 8'h04 with key_press = 8'h04 for one clk; drop it -> keys_active = 0 with key_release = 8'h04 for one clk.
- Bounce: toggle keys_raw[0] every 3 clk for 40 clk, then hold at 1 -> keys_active[0] stays 0 during bouncing; rises exactly 3 ticks after the last agreeing sample; one press pulse only.
- Short pulse: keys_raw[5] high for 2 ticks then low -> keys_active never changes; no events.
- ce gating: drop ce after 2 disagreeing ticks for 50 clk, then restore -> no sample_tick while ce = 0; keys_active updates on the first tick after ce returns.
- Multi-lane plus reset mid-count: press bits 1 and 6 in the same clk -> both accepted in the same cycle with key_press = 8'h42; then assert reset during a pending release -> outputs 0 immediately, no release pulse.
